xoodyak_digest_collector: RTL and testbench

Receive-side companion to `XOODYAK`: captures the byte-serial hash stream (`hash`, `hash_len`, `valid`) and assembles it into a parallel digest register. A downstream consumer reads the digest through a valid/ack handshake. It is armed together with the `start` pulse to `XOODYAK`, and it flags length, gap-timeout and overrun errors.

---
 rtl/xoodyak_pkg.sv | 19 +
 rtl/xoodyak_gap_timer.sv | 29 ++
 rtl/xoodyak_digest_collector.sv | 144 ++++++++++++++
 tb/tb_xoodyak_digest_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the Xoodyak digest receive path.
package xoodyak_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COLLECT,
    ST_DONE,
    ST_ERR
  } collect_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam int XOODYAK_HASH_BYTES = 32;

endpackage

// File: rtl/xoodyak_gap_timer.sv
// Idle-gap counter between hash bytes; expired flags the increment that reaches TIMEOUT.
module xoodyak_gap_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && cnt_q != W'(TIMEOUT)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Look-ahead so the FSM leaves COLLECT on the very edge the count reaches TIMEOUT.
  assign expired = inc && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/xoodyak_digest_collector.sv
// Assembles the byte-serial Xoodyak hash into a parallel digest with valid/ack handoff.
// state   | meaning
// IDLE    | not armed, incoming bytes dropped
// WAIT    | armed, waiting for first byte (latches length)
// COLLECT | capturing remaining bytes, gap timer running
// DONE    | digest complete, digest_valid high until ack
// ERR     | length or timeout error, waits for ack or arm
module xoodyak_digest_collector
  import xoodyak_pkg::*;
#(
  parameter int MAX_BYTES = XOODYAK_HASH_BYTES,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   arm,
  input  logic [7:0]             hash,
  input  logic [7:0]             hash_len,
  input  logic                   valid,
  output logic [8*MAX_BYTES-1:0] digest,
  output logic [7:0]             digest_len,
  output logic                   digest_valid,
  input  logic                   digest_ack,
  output logic                   err,
  output logic [1:0]             err_code
);

  collect_state_t         state_q, state_d;
  logic [8*MAX_BYTES-1:0] digest_q, digest_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             len_q, len_d;
  logic                   err_q, err_d;
  logic [1:0]             code_q, code_d;
  logic                   wr_en;
  logic                   gap_clr, gap_inc, gap_expired;

  xoodyak_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (gap_clr),
    .inc     (gap_inc),
    .expired (gap_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    code_d  = code_q;
    wr_en   = 1'b0;
    gap_clr = 1'b1;
    gap_inc = 1'b0;

    if (arm) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
      len_d   = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end else begin
      case (state_q)
        ST_WAIT: if (valid) begin
          if (hash_len == 8'd0 || int'(hash_len) > MAX_BYTES) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            len_d   = hash_len;
            wr_en   = 1'b1;
            cnt_d   = 8'd1;
            state_d = (hash_len == 8'd1) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          gap_clr = valid;
          if (valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == len_q) state_d = ST_DONE;
          end else begin
            gap_inc = 1'b1;
            if (gap_expired) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              code_d  = ERR_TIMEOUT;
            end
          end
        end
        ST_DONE: begin
          if (digest_ack) begin
            state_d = ST_IDLE;
          end else if (valid) begin
            err_d  = 1'b1;
            code_d = ERR_OVERRUN;
          end
        end
        ST_ERR: if (digest_ack) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
        default: ;
      endcase
    end
  end

  // Per-lane decoded write enable; arm clears every lane.
  always_comb begin
    digest_d = digest_q;
    if (arm) begin
      digest_d = '0;
    end else begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (wr_en && cnt_q == 8'(k)) digest_d[8*k +: 8] = hash;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      digest_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      digest_q <= digest_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign digest       = digest_q;
  assign digest_len   = cnt_q;
  assign digest_valid = (state_q == ST_DONE);
  assign err          = err_q;
  assign err_code     = code_q;

endmodule

// File: tb/tb_xoodyak_digest_collector.sv
// Randomized scenario bench; expected digest built from a byte array per scenario.
module tb_xoodyak_digest_collector;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         arm = 1'b0;
  logic [7:0]   hash = 8'd0;
  logic [7:0]   hash_len = 8'd0;
  logic         valid = 1'b0;
  logic [255:0] digest;
  logic [7:0]   digest_len;
  logic         digest_valid;
  logic         digest_ack = 1'b0;
  logic         err;
  logic [1:0]   err_code;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_b [32];
  int         exp_n;

  xoodyak_digest_collector dut (
    .clk          (clk),
    .resetn       (resetn),
    .arm          (arm),
    .hash         (hash),
    .hash_len     (hash_len),
    .valid        (valid),
    .digest       (digest),
    .digest_len   (digest_len),
    .digest_valid (digest_valid),
    .digest_ack   (digest_ack),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_digest();
    logic [255:0] d = '0;
    for (int k = 0; k < 32; k++) if (k < exp_n) d[8*k +: 8] = exp_b[k];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
    exp_n = 0;
  endtask

  task automatic do_ack();
    digest_ack = 1'b1; tick(); digest_ack = 1'b0;
  endtask

  // Sends one byte; lengths after the first are randomised to show they are ignored.
  task automatic send(input logic [7:0] b, input logic [7:0] l);
    valid = 1'b1; hash = b; hash_len = l; tick();
    valid = 1'b0; hash_len = 8'($urandom);
  endtask

  task automatic collect(input int len, input int max_gap);
    for (int i = 0; i < len; i++) begin
      exp_b[i] = 8'($urandom);
      send(exp_b[i], (i == 0) ? 8'(len) : 8'($urandom));
      exp_n = i + 1;
      if (i < len - 1) repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  initial begin
    int first_err;
    logic [255:0] held;

    tick(); tick();
    check("rst_digest", digest, 0);
    check("rst_len", digest_len, 0);
    check("rst_dv", digest_valid, 0);
    check("rst_err", {err, err_code}, 0);
    resetn = 1'b1;

    // basic 32-byte contiguous hash
    do_arm();
    for (int i = 0; i < 32; i++) begin
      exp_b[i] = 8'(i);
      send(8'(i), (i == 0) ? 8'd32 : 8'($urandom));
      exp_n = i + 1;
      if (i == 30) check("basic_dv_early", digest_valid, 0);
    end
    check("basic_dv", digest_valid, 1);
    check("basic_digest", digest, exp_digest());
    check("basic_len", digest_len, 32);
    do_ack();
    check("basic_ack_dv", digest_valid, 0);
    check("basic_retained", digest, exp_digest());

    // short hash with gaps of 3
    do_arm();
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      send(exp_b[i], (i == 0) ? 8'd4 : 8'($urandom));
      exp_n = i + 1;
      if (i < 3) repeat (3) tick();
    end
    check("short_digest", digest, 256'hD4C3B2A1);
    check("short_dv_err", {digest_valid, err}, 2'b10);
    do_ack();

    // random lengths and gaps
    for (int r = 0; r < 6; r++) begin
      do_arm();
      collect((r == 0) ? 1 : $urandom_range(32, 1), 10);
      check("rnd_digest", digest, exp_digest());
      check("rnd_len", digest_len, 8'(exp_n));
      check("rnd_dv_err", {digest_valid, err, err_code}, 4'b1000);
      do_ack();
      check("rnd_ack_dv", digest_valid, 0);
    end

    // bad length: 0 then 33
    do_arm();
    send(8'h11, 8'd0);
    check("len0_err", {err, err_code, digest_valid}, {1'b1, 2'd1, 1'b0});
    send(8'h22, 8'd4);
    check("len0_ignored", {digest, digest_len, digest_valid}, 0);
    do_ack();
    check("len0_ack_err", {err, err_code}, 0);
    do_arm();
    send(8'h33, 8'd33);
    check("len33_err", {err, err_code, digest_valid}, {1'b1, 2'd1, 1'b0});
    check("len33_digest", digest, 0);
    do_ack();

    // gap timeout after 5 bytes
    do_arm();
    for (int i = 0; i < 5; i++) begin
      exp_b[i] = 8'($urandom);
      send(exp_b[i], (i == 0) ? 8'd32 : 8'($urandom));
      exp_n = i + 1;
    end
    first_err = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (err && first_err == 0) first_err = i;
    end
    check("to_cycle", first_err, 64);
    check("to_code", err_code, 2);
    check("to_len", digest_len, 5);
    check("to_digest", digest, exp_digest());
    check("to_dv", digest_valid, 0);
    do_ack();

    // overrun in DONE
    do_arm();
    collect(3, 2);
    held = exp_digest();
    send(8'h5A, 8'd3);
    check("ovr_code", {err, err_code}, {1'b1, 2'd3});
    check("ovr_digest", digest, held);
    check("ovr_dv", digest_valid, 1);
    do_ack();
    check("ovr_ack_dv", digest_valid, 0);

    // valid coincident with ack: ack wins
    do_arm();
    collect(2, 0);
    valid = 1'b1; hash = 8'hEE; digest_ack = 1'b1; tick();
    valid = 1'b0; digest_ack = 1'b0;
    check("ackv_state", {digest_valid, err, err_code}, 0);
    check("ackv_digest", digest, exp_digest());
    send(8'h77, 8'd2);
    check("idle_drop", {digest, digest_len, err}, {exp_digest(), 8'd2, 1'b0});

    // arm coincident with valid: byte dropped, then WAIT accepts a fresh hash
    arm = 1'b1; valid = 1'b1; hash = 8'h55; hash_len = 8'd2; digest_ack = 1'b1; tick();
    arm = 1'b0; valid = 1'b0; digest_ack = 1'b0;
    exp_n = 0;
    check("armv_clear", {digest, digest_len}, 0);
    collect(2, 1);
    check("armv_digest", digest, exp_digest());
    check("armv_dv", digest_valid, 1);

    // reset mid-collection
    do_arm();
    collect(10, 0);
    hash_len = 8'd32;
    resetn = 1'b0; valid = 1'b1; arm = 1'b1; tick();
    valid = 1'b0; arm = 1'b0;
    check("rst_mid", {digest, digest_len, digest_valid, err, err_code}, 0);
    resetn = 1'b1;
    send(8'h99, 8'd1);
    check("rst_idle", {digest_len, digest_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
